// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect control for the 3-stage core with stall counter and bus timeout
module pipe_ctrl #(
  parameter int AW = 32,
  parameter int FLUSH_CYC = 1,
  parameter int TO_CYC = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          irq_jump_i,
  input  logic [AW-1:0] irq_addr_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ex_hold_i,
  input  logic          bus_hold_i,
  output logic [2:0]    hold_o,
  output logic          jump_flag_o,
  output logic [AW-1:0] jump_addr_o,
  output logic          bus_to_o,
  output logic [31:0]   stall_cnt_o
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t st, st_n;
  logic [3:0] fc, fc_n;
  logic [15:0] to_cnt;
  logic redir, to_hit;
  always_comb begin
    redir = irq_jump_i | jump_i;
    to_hit = to_cnt == 16'(TO_CYC - 1);
    jump_flag_o = !rst && redir;
    jump_addr_o = rst ? '0 : irq_jump_i ? irq_addr_i : jump_i ? jump_addr_i : '0;
    hold_o = rst ? 3'b111 : redir ? 3'b110 :
             ({1'b0, st == FLUSH, 1'b0} | {1'b0, {2{ex_hold_i}}} | {3{bus_hold_i}});
    st_n = st;
    fc_n = fc;
    if (redir) begin
      st_n = FLUSH_CYC > 0 ? FLUSH : RUN;
      fc_n = 4'(FLUSH_CYC);
    end else if (st == FLUSH) begin
      st_n = fc == 4'd1 ? RUN : FLUSH;
      fc_n = fc - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      fc <= '0;
      to_cnt <= '0;
      bus_to_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      st <= st_n;
      fc <= fc_n;
      bus_to_o <= bus_hold_i && to_hit;
      to_cnt <= (!bus_hold_i || to_hit) ? '0 : to_cnt + 16'd1;
      if (hold_o != 3'b000 && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
endmodule
